// File: rtl/a2d_pkg.sv
// Shared constants and types for the A2D SPI responder.
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CHNNL_W    = 3;
  localparam int CNT_W      = 5;
  localparam int CMD_CH_MSB = 13;
  localparam int CMD_CH_LSB = 11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} a2d_resp_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus an edge flop for one asynchronous SPI pin.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic       ff1, ff2, ff3;
  logic [2:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1      <= RST_VAL;
      ff2      <= RST_VAL;
      ff3      <= RST_VAL;
      vld_pipe <= '0;
    end else begin
      ff1      <= din;
      ff2      <= ff1;
      ff3      <= ff2;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
    end
  end

  // Edges are suppressed until the chain holds real pin values, so a pin
  // already away from its reset value does not fake an edge after reset.
  assign sync = ff2;
  assign rise = vld_pipe[2] &  ff2 & ~ff3;
  assign fall = vld_pipe[2] & ~ff2 &  ff3;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for the off-board A2D converter.
// Define A2D_RESP_INV_EN to transmit the 12 data bits complemented.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter int NUM_CHNNL = 8,
  parameter int RES_W     = 12,
  parameter int MIN_HALF  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SS_n,
  input  logic                       SCLK,
  input  logic                       MOSI,
  output logic                       MISO,
  input  logic [NUM_CHNNL*RES_W-1:0] analog,
  output logic                       cmd_vld,
  output logic [CHNNL_W-1:0]         cmd_chnnl,
  output logic                       frm_err
);

  // MISO moves 3 clk after an SCLK fall; a shorter half-period races the master.
  if (MIN_HALF < 4) begin : g_min_half_chk
    $error("a2d_spi_resp: MIN_HALF must be at least 4");
  end

  a2d_resp_state_t state, state_nxt;

  logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_sync;
  logic ss_sync_unused, sclk_sync_unused;
  logic [1:0] mosi_edge_unused;

  logic [FRAME_BITS-1:0] tx_shft, rx_shft;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CHNNL_W-1:0]    chnnl_q;
  logic [RES_W-1:0]      smpl, tx_data;
  logic                  frame_ok, vld_nxt, err_nxt;

  spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .din(SS_n),
    .sync(ss_sync_unused), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(SCLK),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(MOSI),
    .sync(mosi_sync), .rise(mosi_edge_unused[1]), .fall(mosi_edge_unused[0])
  );

  assign smpl = analog[chnnl_q*RES_W +: RES_W];
`ifdef A2D_RESP_INV_EN
  assign tx_data = ~smpl;
`else
  assign tx_data = smpl;
`endif

  assign frame_ok = (bit_cnt == CNT_W'(FRAME_BITS)) && (rx_shft[FRAME_BITS-1 -: 2] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MISO    = 1'b1;
    vld_nxt = 1'b0;
    err_nxt = 1'b0;
    case (state)
      SHIFT: MISO = tx_shft[FRAME_BITS-1];
      DONE: begin
        vld_nxt = frame_ok;
        err_nxt = ~frame_ok;
      end
      default: ;
    endcase
  end

  // Sample is latched at frame start; the pending channel only moves on a good frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft   <= '0;
      rx_shft   <= '0;
      bit_cnt   <= '0;
      chnnl_q   <= '0;
      cmd_vld   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      cmd_vld <= vld_nxt;
      frm_err <= err_nxt;
      if (state == IDLE && ss_fall) begin
        tx_shft <= {{(FRAME_BITS-RES_W){1'b0}}, tx_data};
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        if (sclk_rise) begin
          rx_shft <= {rx_shft[FRAME_BITS-2:0], mosi_sync};
          if (bit_cnt != CNT_W'(FRAME_BITS)) bit_cnt <= bit_cnt + 1'b1;
        end
        if (sclk_fall && bit_cnt != '0 && bit_cnt < CNT_W'(FRAME_BITS))
          tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
      end
      if (state == DONE && frame_ok)
        chnnl_q <= rx_shft[CMD_CH_MSB:CMD_CH_LSB];
    end
  end

  assign cmd_chnnl = chnnl_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: acts as the SPI master and checks line values and pulses.
module tb_a2d_spi_resp;

  localparam int NCH = 8;
  localparam int RW  = 12;
`ifdef A2D_RESP_INV_EN
  localparam logic [11:0] INV = 12'hFFF;
`else
  localparam logic [11:0] INV = 12'h000;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              SS_n = 1'b1;
  logic              SCLK = 1'b1;
  logic              MOSI = 1'b0;
  logic              MISO;
  logic [NCH*RW-1:0] analog = '0;
  logic              cmd_vld;
  logic [2:0]        cmd_chnnl;
  logic              frm_err;

  int n_chk  = 0;
  int n_pass = 0;

  a2d_spi_resp #(.NUM_CHNNL(NCH), .RES_W(RW), .MIN_HALF(4)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .analog(analog), .cmd_vld(cmd_vld), .cmd_chnnl(cmd_chnnl), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_ch(input int ch, input logic [11:0] v);
    analog[ch*RW +: RW] = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master frame; MISO is recorded at each SCLK rise, pulses watched for 8 clk after SS_n rises.
  task automatic frame(input logic [15:0] cmd, input int half, input int nbits,
                       input int chg_bit, input int chg_ch, input logic [11:0] chg_val,
                       output logic [15:0] rx, output int nv, output int ne, output int at);
    rx   = '0;
    SS_n = 1'b0;
    MOSI = cmd[15];
    cyc(half);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      if (i == chg_bit) set_ch(chg_ch, chg_val);
      cyc(half);
      SCLK = 1'b1;
      rx   = {rx[14:0], MISO};
      cyc(half);
    end
    SS_n = 1'b1;
    nv = 0; ne = 0; at = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (cmd_vld) begin nv++; at = c; end
      if (frm_err) begin ne++; at = c; end
    end
    cyc(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rx;
    int nv, ne, at;

    for (int i = 0; i < NCH; i++) set_ch(i, 12'(12'h111 * i));
    set_ch(0, 12'h123);
    set_ch(5, 12'hA5C);

    cyc(2);
    chk("rst_miso", 32'(MISO), 32'h1);
    chk("rst_vld", 32'(cmd_vld), 32'h0);
    chk("rst_err", 32'(frm_err), 32'h0);
    chk("rst_chnnl", 32'(cmd_chnnl), 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // Frame 1 commands ch5 but returns the reset-pending ch0 sample.
    frame(16'h2800, 4, 16, -1, 0, 12'h0, rx, nv, ne, at);
    chk("f1_line", 32'(rx), 32'({4'h0, 12'h123 ^ INV}));
    chk("f1_res", 32'(rx[11:0] ^ INV), 32'h123);
    chk("f1_nv", nv, 1);
    chk("f1_ne", ne, 0);
    chk("f1_at", at, 4);
    chk("f1_chnnl", 32'(cmd_chnnl), 32'h5);

    frame(16'h0000, 4, 16, -1, 0, 12'h0, rx, nv, ne, at);
    chk("f2_res", 32'(rx[11:0] ^ INV), 32'hA5C);
    chk("f2_nv", nv, 1);
    chk("f2_chnnl", 32'(cmd_chnnl), 32'h0);

    set_ch(0, 12'hFFF);
    frame(16'h07FF, 4, 16, -1, 0, 12'h0, rx, nv, ne, at);
    chk("raw_line", 32'(rx), 32'({4'h0, 12'hFFF ^ INV}));
    chk("raw_chnnl", 32'(cmd_chnnl), 32'h0);

    frame(16'h3000, 4, 9, -1, 0, 12'h0, rx, nv, ne, at);
    chk("short_ne", ne, 1);
    chk("short_nv", nv, 0);
    chk("short_at", at, 4);
    chk("short_chnnl", 32'(cmd_chnnl), 32'h0);

    frame(16'h2800, 4, 16, -1, 0, 12'h0, rx, nv, ne, at);
    chk("post_short_res", 32'(rx[11:0] ^ INV), 32'hFFF);
    chk("post_short_chnnl", 32'(cmd_chnnl), 32'h5);

    frame(16'hC000, 4, 16, -1, 0, 12'h0, rx, nv, ne, at);
    chk("bad_ne", ne, 1);
    chk("bad_nv", nv, 0);
    chk("bad_res", 32'(rx[11:0] ^ INV), 32'hA5C);
    chk("bad_chnnl", 32'(cmd_chnnl), 32'h5);

    frame(16'h0800, 4, 16, -1, 0, 12'h0, rx, nv, ne, at);
    chk("post_bad_res", 32'(rx[11:0] ^ INV), 32'hA5C);
    chk("post_bad_chnnl", 32'(cmd_chnnl), 32'h1);

    set_ch(1, 12'h3C3);
    frame(16'h0800, 4, 16, 6, 1, 12'h999, rx, nv, ne, at);
    chk("mid4_res", 32'(rx[11:0] ^ INV), 32'h3C3);
    frame(16'h1000, 16, 16, 3, 1, 12'h555, rx, nv, ne, at);
    chk("mid16_res", 32'(rx[11:0] ^ INV), 32'h999);
    chk("mid16_chnnl", 32'(cmd_chnnl), 32'h2);

    // Reset in the middle of a frame with ch2 pending.
    SS_n = 1'b0;
    cyc(4);
    for (int i = 0; i < 5; i++) begin SCLK = 1'b0; cyc(4); SCLK = 1'b1; cyc(4); end
    rst_n = 1'b0;
    #1;
    chk("mrst_miso", 32'(MISO), 32'h1);
    chk("mrst_chnnl", 32'(cmd_chnnl), 32'h0);
    chk("mrst_pulse", 32'({cmd_vld, frm_err}), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin SCLK = 1'b0; cyc(4); SCLK = 1'b1; cyc(4); end
    SS_n = 1'b1;
    nv = 0; ne = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(1);
      if (cmd_vld) nv++;
      if (frm_err) ne++;
    end
    chk("mrst_nv", nv, 0);
    chk("mrst_ne", ne, 0);
    chk("mrst_idle_miso", 32'(MISO), 32'h1);

    frame(16'h0000, 4, 16, -1, 0, 12'h0, rx, nv, ne, at);
    chk("mrst_res", 32'(rx[11:0] ^ INV), 32'hFFF);
    chk("mrst_f_nv", nv, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
